// File: rtl/clint_vec.sv
// clint_vec - core-local interrupt/trap sequencer.
//
// Sits beside the execute stage and the CSR file. It arbitrates NUM_IRQ maskable
// level interrupts (lowest index wins) together with ECALL, EBREAK and MRET. For
// a trap it writes mepc, mstatus and mcause through the CSR write port on three
// consecutive cycles and then redirects the pipeline, either to the direct mtvec
// base or to a vectored slot. For MRET it restores mstatus and the privilege
// level and then redirects to mepc.
//
// Ports
//   sys_clk, sys_reset        clock, asynchronous active-high reset
//   instr_i, pc_i             instruction in execute and its PC
//   jump_flag_i, jump_addr_i  taken branch/jump this cycle and its target
//   stall_i, stall_pc_i       multicycle op in flight and its PC
//   irq_i, irq_en_i           level interrupt requests and per-line enables
//   csr_mtvec/mepc/mstatus    current CSR values
//   privilege_i               current privilege level
//   wr_en_o/addr_o/data_o     CSR write port (registered)
//   wr_privilege_en_o/ctrl_o  privilege update strobe and value
//   irq_claim_o               one-hot, one-cycle acknowledge of the taken line
//   busy_o                    sequence in progress, pipeline must hold
//   int_assert_o, int_addr_o  one-cycle redirect pulse and its target
module clint_vec #(
  parameter int NUM_IRQ    = 8,
  parameter int CAUSE_BASE = 16,
  parameter bit VECTOR_EN  = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  input  logic [31:0]        instr_i,
  input  logic [31:0]        pc_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               stall_i,
  input  logic [31:0]        stall_pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  input  logic [1:0]         privilege_i,
  output logic               wr_en_o,
  output logic [11:0]        wr_addr_o,
  output logic [31:0]        wr_data_o,
  output logic               wr_privilege_en_o,
  output logic [1:0]         wr_privilege_ctrl_o,
  output logic [NUM_IRQ-1:0] irq_claim_o,
  output logic               busy_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TRAP_MEPC    = 3'd1,
    TRAP_MSTATUS = 3'd2,
    TRAP_MCAUSE  = 3'd3,
    MRET_ST      = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] epc_r;
  logic [31:0] cause_r;
  logic        async_r;
  logic [1:0]  priv_r;

  logic [NUM_IRQ-1:0] eff_s;
  logic               async_req_s;
  logic [4:0]         win_idx_s;
  logic [NUM_IRQ-1:0] win_onehot_s;
  logic [31:0]        irq_cause_s;
  logic [31:0]        irq_epc_s;
  logic               is_ecall_s;
  logic               is_ebreak_s;
  logic               is_mret_s;
  logic               sync_ok_s;
  logic               accept_s;
  logic [31:0]        trap_mstatus_s;
  logic [31:0]        mret_mstatus_s;
  logic [31:0]        trap_base_s;
  logic [31:0]        trap_target_s;

  // Index of the lowest set bit; scanning downwards lets the lowest index overwrite.
  function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = 5'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Event decode: pending interrupts, winner, instruction type and interrupted PC.
  always_comb begin
    eff_s        = irq_i & irq_en_i;
    async_req_s  = (|eff_s) && csr_mstatus[3];
    win_idx_s    = lowest_idx(eff_s);
    win_onehot_s = NUM_IRQ'(1) << win_idx_s;
    irq_cause_s  = {1'b1, 31'(CAUSE_BASE) + {26'd0, win_idx_s}};
    is_ecall_s   = (instr_i == INSTR_ECALL);
    is_ebreak_s  = (instr_i == INSTR_EBREAK);
    is_mret_s    = (instr_i == INSTR_MRET);
    sync_ok_s    = !jump_flag_i && !stall_i;
    // The interrupt resumes where the pipeline would have gone next.
    if (jump_flag_i) begin
      irq_epc_s = jump_addr_i;
    end else if (stall_i) begin
      irq_epc_s = stall_pc_i;
    end else begin
      irq_epc_s = pc_i;
    end
    // The cycle a redirect is asserted still counts as busy, so nothing is accepted.
    accept_s = (state_r == IDLE) && !int_assert_o;
  end

  // CSR write data and redirect target for the sequencing states.
  always_comb begin
    trap_mstatus_s        = csr_mstatus;
    trap_mstatus_s[7]     = csr_mstatus[3];
    trap_mstatus_s[3]     = 1'b0;
    trap_mstatus_s[12:11] = priv_r;

    mret_mstatus_s        = csr_mstatus;
    mret_mstatus_s[3]     = csr_mstatus[7];
    mret_mstatus_s[7]     = 1'b1;
    mret_mstatus_s[12:11] = 2'b00;

    trap_base_s = {csr_mtvec[31:2], 2'b00};
    // Vectored slot offset is 4*cause code; the code sits in the low bits of cause_r.
    if (VECTOR_EN && (csr_mtvec[1:0] == 2'b01) && async_r) begin
      trap_target_s = trap_base_s + {cause_r[29:0], 2'b00};
    end else begin
      trap_target_s = trap_base_s;
    end
  end

  assign busy_o = (state_r != IDLE) || int_assert_o;

  // Sequencer state, captured trap context and all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_r             <= IDLE;
      epc_r               <= 32'd0;
      cause_r             <= 32'd0;
      async_r             <= 1'b0;
      priv_r              <= 2'b00;
      wr_en_o             <= 1'b0;
      wr_addr_o           <= 12'd0;
      wr_data_o           <= 32'd0;
      wr_privilege_en_o   <= 1'b0;
      wr_privilege_ctrl_o <= 2'b11;
      irq_claim_o         <= '0;
      int_assert_o        <= 1'b0;
      int_addr_o          <= 32'd0;
    end else begin
      wr_en_o           <= 1'b0;
      wr_addr_o         <= 12'd0;
      wr_data_o         <= 32'd0;
      wr_privilege_en_o <= 1'b0;
      irq_claim_o       <= '0;
      int_assert_o      <= 1'b0;
      int_addr_o        <= 32'd0;
      case (state_r)
        IDLE: begin
          if (accept_s && async_req_s) begin
            state_r     <= TRAP_MEPC;
            epc_r       <= irq_epc_s;
            cause_r     <= irq_cause_s;
            async_r     <= 1'b1;
            priv_r      <= privilege_i;
            irq_claim_o <= win_onehot_s;
          end else if (accept_s && (is_ecall_s || is_ebreak_s) && sync_ok_s) begin
            state_r <= TRAP_MEPC;
            epc_r   <= pc_i;
            cause_r <= is_ecall_s ? 32'd11 : 32'd3;
            async_r <= 1'b0;
            priv_r  <= privilege_i;
          end else if (accept_s && is_mret_s) begin
            state_r <= MRET_ST;
          end else begin
            state_r <= IDLE;
          end
        end
        TRAP_MEPC: begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= CSR_MEPC;
          wr_data_o <= epc_r;
          state_r   <= TRAP_MSTATUS;
        end
        TRAP_MSTATUS: begin
          wr_en_o             <= 1'b1;
          wr_addr_o           <= CSR_MSTATUS;
          wr_data_o           <= trap_mstatus_s;
          wr_privilege_en_o   <= 1'b1;
          wr_privilege_ctrl_o <= 2'b11;
          state_r             <= TRAP_MCAUSE;
        end
        TRAP_MCAUSE: begin
          wr_en_o      <= 1'b1;
          wr_addr_o    <= CSR_MCAUSE;
          wr_data_o    <= cause_r;
          int_assert_o <= 1'b1;
          int_addr_o   <= trap_target_s;
          state_r      <= IDLE;
        end
        MRET_ST: begin
          wr_en_o             <= 1'b1;
          wr_addr_o           <= CSR_MSTATUS;
          wr_data_o           <= mret_mstatus_s;
          wr_privilege_en_o   <= 1'b1;
          wr_privilege_ctrl_o <= csr_mstatus[12:11];
          int_assert_o        <= 1'b1;
          int_addr_o          <= csr_mepc;
          state_r             <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
